// File: rtl/belt_warn_timed_if.sv
// Cabin sensor inputs and dashboard lamp/chime outputs of the seat-belt warning block.
interface belt_warn_timed_if #(
  parameter int unsigned N_SEATS = 2
);
  logic               k;
  logic [N_SEATS-1:0] p;
  logic [N_SEATS-1:0] s;
  logic               w;
  logic               chime;
  logic [N_SEATS-1:0] seat_warn;

  modport master (output k, p, s, input w, chime, seat_warn);
  modport slave  (input k, p, s, output w, chime, seat_warn);
endinterface

// File: rtl/belt_warn_timed.sv
// Timed multi-seat seat-belt warning: grace period, then a lamp and a pulsed chime
// that silences after a fixed time. A newly unsafe seat restarts the chime.
module belt_warn_timed #(
  parameter int unsigned N_SEATS      = 2,
  parameter int unsigned GRACE        = 4,
  parameter int unsigned CHIME_HALF   = 2,
  parameter int unsigned CHIME_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  belt_warn_timed_if.slave bus
);

  localparam int unsigned GW = (GRACE        > 1) ? $clog2(GRACE)        : 1;
  localparam int unsigned HW = (CHIME_HALF   > 1) ? $clog2(CHIME_HALF)   : 1;
  localparam int unsigned CW = (CHIME_CYCLES > 1) ? $clog2(CHIME_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_ARMED  = 2'd1,
    ST_WARN   = 2'd2,
    ST_SILENT = 2'd3
  } state_t;

  state_t             r_state,     w_state_nx;
  logic [GW-1:0]      r_grace,     w_grace_nx;
  logic [HW-1:0]      r_half,      w_half_nx;
  logic [CW-1:0]      r_cyc,       w_cyc_nx;
  logic [N_SEATS-1:0] r_mask,      w_mask_nx;
  logic               r_w,         w_w_nx;
  logic               r_chime,     w_chime_nx;
  logic [N_SEATS-1:0] r_seat_warn, w_seat_warn_nx;

  logic [N_SEATS-1:0] w_unsafe;
  logic               w_any;
  logic               w_new;
  logic               w_enter;
  logic               w_clear;

  // Next-state and next-output logic
  always_comb begin
    w_unsafe       = bus.p & ~bus.s;
    w_any          = |w_unsafe;
    w_new          = |(w_unsafe & ~r_mask);
    w_state_nx     = r_state;
    w_grace_nx     = r_grace;
    w_half_nx      = r_half;
    w_cyc_nx       = r_cyc;
    w_mask_nx      = r_mask;
    w_chime_nx     = 1'b0;
    w_w_nx         = 1'b0;
    w_seat_warn_nx = '0;
    w_enter        = 1'b0;
    w_clear        = 1'b0;

    if (!bus.k) begin
      w_state_nx = ST_OFF;
      w_clear    = 1'b1;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_nx = ST_ARMED;
          w_grace_nx = '0;
        end
        ST_ARMED: begin
          if (!w_any) begin
            w_grace_nx = '0;
          end else if (r_grace == GW'(GRACE - 1)) begin
            w_enter = 1'b1;
          end else begin
            w_grace_nx = r_grace + GW'(1);
          end
        end
        ST_WARN: begin
          if (!w_any) begin
            w_state_nx = ST_ARMED;
            w_clear    = 1'b1;
          end else if (r_cyc == CW'(CHIME_CYCLES - 1)) begin
            w_state_nx = ST_SILENT;
            w_half_nx  = '0;
            w_cyc_nx   = '0;
            w_mask_nx  = r_mask | w_unsafe;
          end else begin
            w_cyc_nx  = r_cyc + CW'(1);
            w_mask_nx = r_mask | w_unsafe;
            if (r_half == HW'(CHIME_HALF - 1)) begin
              w_half_nx  = '0;
              w_chime_nx = ~r_chime;
            end else begin
              w_half_nx  = r_half + HW'(1);
              w_chime_nx = r_chime;
            end
          end
        end
        ST_SILENT: begin
          if (!w_any) begin
            w_state_nx = ST_ARMED;
            w_clear    = 1'b1;
          end else if (w_new) begin
            w_enter = 1'b1;
          end else begin
            w_mask_nx = r_mask | w_unsafe;
          end
        end
        default: begin
          w_state_nx = ST_OFF;
          w_clear    = 1'b1;
        end
      endcase
    end

    // Warning entry restarts the chime and reloads the seat mask from the current seats
    if (w_enter) begin
      w_state_nx = ST_WARN;
      w_grace_nx = '0;
      w_half_nx  = '0;
      w_cyc_nx   = '0;
      w_mask_nx  = w_unsafe;
      w_chime_nx = 1'b1;
    end
    if (w_clear) begin
      w_grace_nx = '0;
      w_half_nx  = '0;
      w_cyc_nx   = '0;
      w_mask_nx  = '0;
      w_chime_nx = 1'b0;
    end

    w_w_nx         = (w_state_nx == ST_WARN) || (w_state_nx == ST_SILENT);
    w_seat_warn_nx = w_w_nx ? w_unsafe : '0;
  end

  // State, counters and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_OFF;
      r_grace     <= '0;
      r_half      <= '0;
      r_cyc       <= '0;
      r_mask      <= '0;
      r_w         <= 1'b0;
      r_chime     <= 1'b0;
      r_seat_warn <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_grace     <= w_grace_nx;
      r_half      <= w_half_nx;
      r_cyc       <= w_cyc_nx;
      r_mask      <= w_mask_nx;
      r_w         <= w_w_nx;
      r_chime     <= w_chime_nx;
      r_seat_warn <= w_seat_warn_nx;
    end
  end

  assign bus.w         = r_w;
  assign bus.chime     = r_chime;
  assign bus.seat_warn = r_seat_warn;

endmodule

// File: tb/tb_belt_warn_timed.sv
// Directed test-plan steps plus a randomized run, checked against a timeline model of the warning.
module tb_belt_warn_timed;

  localparam int unsigned NS   = 2;
  localparam int unsigned GR   = 4;
  localparam int unsigned HALF = 2;
  localparam int unsigned CYC  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  belt_warn_timed_if #(.N_SEATS(NS)) bus ();

  belt_warn_timed #(
    .N_SEATS(NS), .GRACE(GR), .CHIME_HALF(HALF), .CHIME_CYCLES(CYC)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: key-on flag, unsafe run length, warning flag, time since warning start
  bit          m_on;
  bit          m_warning;
  int          m_run;
  int          m_t;
  logic [NS-1:0] m_mask;
  logic [NS-1:0] m_unsafe;

  task automatic model_reset();
    m_on = 0; m_warning = 0; m_run = 0; m_t = 0; m_mask = '0; m_unsafe = '0;
  endtask

  task automatic model_edge();
    m_unsafe = bus.p & ~bus.s;
    if (!bus.k) begin
      m_on = 0; m_warning = 0; m_run = 0; m_t = 0; m_mask = '0;
    end else if (!m_on) begin
      m_on = 1; m_run = 0;
    end else if (!m_warning) begin
      if (m_unsafe != 0) begin
        m_run++;
        if (m_run >= GR) begin
          m_warning = 1; m_t = 0; m_mask = m_unsafe; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (m_unsafe == 0) begin
      m_warning = 0; m_run = 0; m_t = 0; m_mask = '0;
    end else if (m_t >= CYC && (m_unsafe & ~m_mask) != 0) begin
      m_t = 0; m_mask = m_unsafe;
    end else begin
      if (m_t < CYC) m_t++;
      m_mask = m_mask | m_unsafe;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic exp_chime;
    exp_chime = m_warning && (m_t < CYC) && (((m_t / HALF) % 2) == 0);
    chk({tag, ".w"},     8'(bus.w),         8'(m_warning));
    chk({tag, ".chime"}, 8'(bus.chime),     8'(exp_chime));
    chk({tag, ".seat"},  8'(bus.seat_warn), 8'(m_warning ? m_unsafe : 2'b00));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.k = 1'b0; bus.p = 2'b11; bus.s = 2'b00;
    model_reset();
    #1;
    check_model("reset_hold");
    do_reset();

    // Key off with unsafe seats never warns
    for (int i = 0; i < 8; i++) tick("keyoff");

    // Basic warning timeline on seat 0
    bus.k = 1'b1; bus.p = 2'b01; bus.s = 2'b00;
    for (int e = 1; e <= 24; e++) begin
      tick("basic");
      if (e == 4)  chk("basic_w_e4", 8'(bus.w), 8'd0);
      if (e == 5)  begin
        chk("basic_w_e5", 8'(bus.w), 8'd1);
        chk("basic_ch_e5", 8'(bus.chime), 8'd1);
        chk("basic_sw_e5", 8'(bus.seat_warn), 8'h01);
      end
      if (e == 7)  chk("basic_ch_e7", 8'(bus.chime), 8'd0);
      if (e == 17) chk("basic_ch_e17", 8'(bus.chime), 8'd1);
      if (e == 21) begin
        chk("silent_w", 8'(bus.w), 8'd1);
        chk("silent_ch", 8'(bus.chime), 8'd0);
      end
    end

    // Newly unsafe seat in SILENT re-enters WARN immediately
    bus.p = 2'b11;
    tick("rewarn");
    chk("rewarn_ch", 8'(bus.chime), 8'd1);
    chk("rewarn_sw", 8'(bus.seat_warn), 8'h03);
    for (int i = 0; i < 3; i++) tick("rewarn_run");

    // Buckling all seats drops to ARMED; unbuckling needs the full grace again
    bus.s = 2'b11;
    tick("buckle");
    chk("buckle_w", 8'(bus.w), 8'd0);
    bus.s = 2'b00;
    for (int e = 1; e <= 4; e++) begin
      tick("regrace");
      if (e == 3) chk("regrace_w_e3", 8'(bus.w), 8'd0);
      if (e == 4) chk("regrace_w_e4", 8'(bus.w), 8'd1);
    end
    tick("warn2");

    // Key off in WARN
    bus.k = 1'b0;
    tick("keydrop");
    chk("keydrop_w", 8'(bus.w), 8'd0);
    bus.k = 1'b1;
    for (int i = 0; i < 7; i++) tick("rearm");
    chk("rearm_w", 8'(bus.w), 8'd1);

    // Asynchronous reset mid-WARN, between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_w", 8'(bus.w), 8'd0);
    chk("async_ch", 8'(bus.chime), 8'd0);
    chk("async_sw", 8'(bus.seat_warn), 8'h00);
    model_reset();
    bus.k = 1'b0;
    do_reset();

    // Grace restart by a one-cycle buckle
    bus.k = 1'b1; bus.p = 2'b01; bus.s = 2'b00;
    for (int e = 1; e <= 10; e++) begin
      tick("grace_rst");
      if (e == 3) bus.s = 2'b01;
      if (e == 4) bus.s = 2'b00;
      if (e == 7) chk("grace_w_e7", 8'(bus.w), 8'd0);
      if (e == 8) chk("grace_w_e8", 8'(bus.w), 8'd1);
    end

    // Randomized run with slowly changing seat inputs
    for (int i = 0; i < 600; i++) begin
      bus.k = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 9) == 0) bus.p = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) bus.s = 2'($urandom_range(0, 3));
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/belt_warn_timed.md
Name: belt_warn_timed

Overview:
Multi-seat, timed successor to the single-seat combinational seat-belt warning. Watches ignition key, per-seat occupancy and per-seat buckle inputs. After a grace period, raises a warning light plus a pulsed chime for any occupied, unbuckled seat. The chime stops after a fixed time; the light stays on. Sits between the debounced cabin sensor inputs and the dashboard lamp/chime drivers.

Parameters:
N_SEATS, 2, number of monitored seats (>=1)
GRACE, 4, consecutive cycles an unsafe condition must persist before warning (>=1)
CHIME_HALF, 2, cycles per chime half-period, high then low (>=1)
CHIME_CYCLES, 16, cycles the chime is active before silencing (>=1)
(Internal counter widths are derived with $clog2; there is no width parameter.)

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-high reset
K  in  1  ignition key on
P  in  N_SEATS  seat occupied, one bit per seat
S  in  N_SEATS  seat belt buckled, one bit per seat
W  out  1  warning light
Chime  out  1  chime drive, pulsed
SeatWarn  out  N_SEATS  per-seat unsafe indication while warning

Behaviour:
- unsafe[i] = P[i] & ~S[i]. any_unsafe = OR of unsafe.
- All outputs are registered and change only on a Clk edge or on Rst.
- Rst: state OFF. W=0, Chime=0, SeatWarn=0. All counters and the seat mask are cleared. Rst asserted mid-warning clears everything immediately.
- States: OFF, ARMED, WARN, SILENT. K=0 has top priority: from any state, the next state is OFF with all outputs 0 on the next edge.
- OFF: K=1 moves to ARMED. The grace counter is cleared.
- ARMED: W=0, Chime=0.
  - Each edge with any_unsafe=1 increments the grace counter.
  - An edge with any_unsafe=0 clears the counter.
  - On the GRACE-th consecutive edge sampling any_unsafe=1, the block moves to WARN.
- WARN entry (same edge):
  - W=1 and Chime=1.
  - The chime and warn counters clear.
  - mask <= unsafe.
- WARN:
  - Chime toggles every CHIME_HALF edges.
  - After CHIME_CYCLES edges in WARN, the block moves to SILENT with Chime=0.
  - any_unsafe=0 moves to ARMED on the next edge (W=0, Chime=0, counters cleared).
- SILENT:
  - W=1, Chime=0.
  - any_unsafe=0 moves to ARMED.
  - A newly unsafe seat (unsafe & ~mask nonzero) re-enters WARN immediately, with no grace period. The chime restarts and mask <= unsafe.
- In WARN and SILENT, a newly unsafe seat does not restart the chime while still in WARN. The mask accumulates: mask <= mask | unsafe.
- SeatWarn <= unsafe when the next state is WARN or SILENT, else 0.
- Simultaneous events:
  - K falling on the same edge as the grace expiry results in OFF.
  - any_unsafe=0 on the same edge as chime expiry results in ARMED.
- The chime counter wraps are internal; there is no overflow outcome, because the state leaves WARN first.

Test Plan (N_SEATS=2, GRACE=4, CHIME_HALF=2, CHIME_CYCLES=16):
1. Reset held, then released with K=0, P=11, S=00 -> W=0, Chime=0, SeatWarn=00 indefinitely.
2. K=1, P=01, S=00 held from edge 0 -> ARMED at edge 1, W=1 and Chime=1 at edge 5. Chime pattern is 1,1,0,0,... for 16 cycles, then Chime=0 with W=1. SeatWarn=01.
3. As in 2, with S=01 applied at edge 3 and removed at edge 4 -> the grace counter restarts, and W rises at edge 8.
4. In SILENT with P=01, S=00, set P=11 -> the next edge gives WARN, Chime=1, SeatWarn=11, with no grace delay.
5. In WARN, set S=11 -> the next edge gives W=0, Chime=0, SeatWarn=00. Then set S=00 -> W rises only after 4 more edges.
6. In WARN, drop K to 0 -> the next edge gives OFF with all outputs 0. Assert Rst asynchronously mid-WARN -> outputs are 0 without waiting for a clock edge.
